// File: rtl/sym2_seq_tx_if.sv
// Controller-side bus for sym2_seq_tx: start/pattern/length toward the
// transmitter, serialised symbol, status and present-state bits back.
// SYM2_SEQ_TX_LOOP_EN adds the loop request line.
interface sym2_seq_tx_if #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
);
  logic                 start;
`ifdef SYM2_SEQ_TX_LOOP_EN
  logic                 loop;
`endif
  logic [2*DEPTH-1:0]   pattern;
  logic [LEN_W-1:0]     length;
  logic                 x1;
  logic                 x0;
  logic                 sym_valid;
  logic                 busy;
  logic                 done;
  logic                 ps1;
  logic                 ps0;

`ifdef SYM2_SEQ_TX_LOOP_EN
  modport master (
    output start, loop, pattern, length,
    input  x1, x0, sym_valid, busy, done, ps1, ps0
  );
  modport slave (
    input  start, loop, pattern, length,
    output x1, x0, sym_valid, busy, done, ps1, ps0
  );
`else
  modport master (
    output start, pattern, length,
    input  x1, x0, sym_valid, busy, done, ps1, ps0
  );
  modport slave (
    input  start, pattern, length,
    output x1, x0, sym_valid, busy, done, ps1, ps0
  );
`endif
endinterface

// File: rtl/sym2_seq_tx.sv
// Serialises a parallel-loaded pattern of 2-bit symbols onto x1/x0, one
// symbol per HOLD_CYCLES clocks, followed by GAP_CYCLES idle clocks and a
// one-cycle done pulse. Present state is exported on ps1/ps0.
// Optional macro SYM2_SEQ_TX_LOOP_EN: loop=1 at the end of a pass restarts
// the captured pattern instead of finishing.
module sym2_seq_tx #(
  parameter int DEPTH       = 8,
  parameter int LEN_W       = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic         clock,
  input  logic         clear,
  sym2_seq_tx_if.slave bus
);

  localparam int IDX_W  = (DEPTH > 1)       ? $clog2(DEPTH)       : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

  localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [IDX_W-1:0]   last_idx, last_idx_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [2*DEPTH-1:0] pat_q, pat_n;
  logic [1:0]         sym_q, sym_n;
  logic               sv_q, sv_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [LEN_W-1:0]   len_eff;
  logic               seq_end;

  function automatic logic [1:0] sym_at(input logic [2*DEPTH-1:0] p,
                                        input logic [IDX_W-1:0]   i);
    sym_at = p[2*i +: 2];
  endfunction

  // State, counters, captured pattern and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      pat_q    <= '0;
      sym_q    <= '0;
      sv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last_idx <= last_idx_n;
      hold_cnt <= hold_cnt_n;
      gap_cnt  <= gap_cnt_n;
      pat_q    <= pat_n;
      sym_q    <= sym_n;
      sv_q     <= sv_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead
  // so every port comes straight from a flop
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_idx_n = last_idx;
    hold_cnt_n = hold_cnt;
    gap_cnt_n  = gap_cnt;
    pat_n      = pat_q;
    sym_n      = '0;
    sv_n       = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    seq_end    = 1'b0;
    len_eff    = (bus.length > DEPTH_LEN) ? DEPTH_LEN : bus.length;

    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_n      = bus.pattern;
          last_idx_n = IDX_W'(len_eff - LEN_W'(1));
          idx_n      = '0;
          hold_cnt_n = '0;
          if (len_eff == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SEND;
            sym_n   = bus.pattern[1:0];
            sv_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end

      SEND: begin
        busy_n = 1'b1;
        sv_n   = 1'b1;
        sym_n  = sym_q;
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end else begin
          hold_cnt_n = '0;
          if (idx != last_idx) begin
            idx_n = idx + IDX_W'(1);
            sym_n = sym_at(pat_q, idx + IDX_W'(1));
          end else if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = '0;
            sym_n     = '0;
            sv_n      = 1'b0;
          end else begin
            seq_end = 1'b1;
          end
        end
      end

      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          seq_end = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // End of a pass is shared by the last GAP clock and, with no gap, the
    // last SEND hold clock; looping restarts symbol 0 from the captured pattern
    if (seq_end) begin
      state_n = DONE;
      done_n  = 1'b1;
      busy_n  = 1'b0;
      sv_n    = 1'b0;
      sym_n   = '0;
`ifdef SYM2_SEQ_TX_LOOP_EN
      if (bus.loop) begin
        state_n    = SEND;
        done_n     = 1'b0;
        busy_n     = 1'b1;
        sv_n       = 1'b1;
        idx_n      = '0;
        hold_cnt_n = '0;
        sym_n      = sym_at(pat_q, '0);
      end
`endif
    end
  end

  assign bus.x1        = sym_q[1];
  assign bus.x0        = sym_q[0];
  assign bus.sym_valid = sv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ps1       = state[1];
  assign bus.ps0       = state[0];

endmodule

// File: tb/tb_sym2_seq_tx.sv
// Self-checking bench for sym2_seq_tx: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3, both DEPTH=8, GAP_CYCLES=2, 20 ns clock.
// Expected traces come from a per-transfer list of cycles built from the
// symbol/hold/gap/done rules.
module tb_sym2_seq_tx;

  localparam int unsigned HOLD0 = 1;
  localparam int unsigned HOLD1 = 3;
  localparam int unsigned GAPC  = 2;

  logic clock = 1'b0;
  logic clear;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Each entry: {ps1,ps0,x1,x0,sym_valid,busy,done}
  logic [6:0] exp_q[$];

  sym2_seq_tx_if #(.DEPTH(8), .LEN_W(4)) b0 ();
  sym2_seq_tx_if #(.DEPTH(8), .LEN_W(4)) b1 ();

  sym2_seq_tx #(.DEPTH(8), .LEN_W(4), .HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAPC)) dut_h1 (
    .clock (clock),
    .clear (clear),
    .bus   (b0.slave)
  );

  sym2_seq_tx #(.DEPTH(8), .LEN_W(4), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAPC)) dut_h3 (
    .clock (clock),
    .clear (clear),
    .bus   (b1.slave)
  );

  always #10 clock = ~clock;

  function automatic logic [6:0] observe(input int sel);
    if (sel == 0)
      return {b0.ps1, b0.ps0, b0.x1, b0.x0, b0.sym_valid, b0.busy, b0.done};
    return {b1.ps1, b1.ps0, b1.x1, b1.x0, b1.sym_valid, b1.busy, b1.done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) b0.start = v;
    else          b1.start = v;
  endtask

  task automatic check(input int sel, input string tag, input int unsigned n,
                       input logic [6:0] exp);
    logic [6:0] got;
    got = observe(sel);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] dut%0d: observed ps/x/sv/busy/done=%b expected %b",
             tag, n, sel, got, exp);
    end
  endtask

  // Cycle-by-cycle expectation from the start edge through the first IDLE
  task automatic model(input logic [15:0] pat, input int unsigned len,
                       input int unsigned hold);
    int unsigned l;
    l = (len > 8) ? 8 : len;
    exp_q.delete();
    for (int unsigned i = 0; i < l; i++)
      for (int unsigned h = 0; h < hold; h++)
        exp_q.push_back({2'b01, pat[2*i+1], pat[2*i], 3'b110});
    if (l > 0)
      for (int unsigned g = 0; g < GAPC; g++)
        exp_q.push_back(7'b10_00_010);
    exp_q.push_back(7'b11_00_001);
    exp_q.push_back(7'b00_00_000);
  endtask

  // One transfer; after the start edge the inputs are scrambled and start
  // is poked at random, none of which may disturb the transfer
  task automatic run(input int sel, input logic [15:0] pat, input logic [3:0] len,
                     input string tag);
    model(pat, len, (sel == 0) ? HOLD0 : HOLD1);
    b0.pattern = pat;
    b1.pattern = pat;
    b0.length  = len;
    b1.length  = len;
    set_start(sel, 1'b1);
    foreach (exp_q[j]) begin
      tick();
      check(sel, tag, j, exp_q[j]);
      b0.pattern = 16'($urandom);
      b1.pattern = 16'($urandom);
      b0.length  = 4'($urandom);
      b1.length  = 4'($urandom);
      set_start(sel, (j + 1 < exp_q.size()) ? 1'($urandom) : 1'b0);
    end
    tick();
    check(sel, {tag, "_idle"}, 0, 7'b0);
  endtask

  initial begin : stim
    logic [15:0] pat;

    clear      = 1'b1;
    b0.start   = 1'b1;
    b1.start   = 1'b1;
    b0.pattern = 16'hFFFF;
    b1.pattern = 16'hFFFF;
    b0.length  = 4'd8;
    b1.length  = 4'd8;
`ifdef SYM2_SEQ_TX_LOOP_EN
    b0.loop    = 1'b0;
    b1.loop    = 1'b0;
`endif

    // Reset with start held high: clear wins
    for (int unsigned r = 0; r < 2; r++) begin
      tick();
      check(0, "reset", r, 7'b0);
      check(1, "reset", r, 7'b0);
    end
    clear    = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    tick();
    check(0, "post_reset", 0, 7'b0);

    // Directed basic send: symbols 00,01,10,11
    run(0, 16'h00E4, 4'd4, "basic");

    // Length clamp with 3-clock hold: 8 symbols, done 26 edges after start
    run(1, 16'($urandom), 4'd12, "clamp_h3");

    // Zero length: straight to DONE
    run(0, 16'($urandom), 4'd0, "zero_len");
    run(1, 16'($urandom), 4'd0, "zero_len_h3");

    // Full depth, all-zero symbols still valid
    run(0, 16'h0000, 4'd8, "zero_syms");

    // Abort at symbol 2, with start re-asserted during SEND
    pat = 16'($urandom);
    model(pat, 8, HOLD0);
    b0.pattern = pat;
    b0.length  = 4'd8;
    b0.start   = 1'b1;
    for (int unsigned j = 0; j < 3; j++) begin
      tick();
      check(0, "abort_pre", j, exp_q[j]);
      b0.start = (j == 0) ? 1'b0 : 1'b1;
    end
    clear = 1'b1;
    tick();
    check(0, "abort_clear", 0, 7'b0);
    clear    = 1'b0;
    b0.start = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      tick();
      check(0, "abort_quiet", j, 7'b0);
    end

    // Randomised transfers on both instances
    for (int r = 0; r < 12; r++)
      run((r % 3 == 2) ? 1 : 0, 16'($urandom), 4'($urandom), "rand");

`ifdef SYM2_SEQ_TX_LOOP_EN
    // Loop: three passes of two symbols, loop dropped during the third
    pat = 16'($urandom);
    exp_q.delete();
    for (int unsigned p = 0; p < 3; p++) begin
      exp_q.push_back({2'b01, pat[1], pat[0], 3'b110});
      exp_q.push_back({2'b01, pat[3], pat[2], 3'b110});
      exp_q.push_back(7'b10_00_010);
      exp_q.push_back(7'b10_00_010);
    end
    exp_q.push_back(7'b11_00_001);
    exp_q.push_back(7'b00_00_000);
    b0.pattern = pat;
    b0.length  = 4'd2;
    b0.loop    = 1'b1;
    b0.start   = 1'b1;
    foreach (exp_q[j]) begin
      tick();
      check(0, "loop", j, exp_q[j]);
      b0.start = 1'b0;
      if (j == 8) b0.loop = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
